mul_sequencer: RTL and testbench

Multi-cycle multiply controller for the ARM pipeline. It accepts a MUL/UMULL issue pulse, runs an iterative radix-2 shift-add multiply while freezing the pipeline, then writes the 32-bit result (or both 64-bit halves to Rd and Rd+1) into the register file. It shares the register-file write port with the WB stage and always gives WB priority.

---
 rtl/mul_sequencer.sv | 161 ++++++++++++++++
 tb/tb_mul_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_sequencer.sv
// mul_sequencer: iterative radix-2 shift-add multiply controller.
// Accepts a MUL/UMULL issue pulse, runs WIDTH shift-add iterations while
// freezing the front of the pipeline, then writes the low word (and, for
// long multiplies, the high word to dest+1) through the register-file write
// port it shares with the WB stage. WB always wins the port.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   start                 issue pulse, sampled only in IDLE
//   is_long               1 = 64-bit result (lo -> dest, hi -> dest+1)
//   dest                  destination register
//   op_a, op_b            multiplicand / multiplier
//   wb_stage_en/dest/value  WB stage write request (priority)
//   rf_wb_en/dest/value   arbitrated register-file write port
//   freeze                stall for IF/ID and ID/EX while busy
//   done                  pulse on the final result write
module mul_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_long,
    input  logic [3:0]       dest,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             wb_stage_en,
    input  logic [3:0]       wb_stage_dest,
    input  logic [31:0]      wb_stage_value,
    output logic             rf_wb_en,
    output logic [3:0]       rf_wb_dest,
    output logic [31:0]      rf_wb_value,
    output logic             freeze,
    output logic             done
);

    localparam int unsigned REG_W = 4;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WR_LO = 2'd2,
        WR_HI = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] ma;
    logic [WIDTH-1:0] mb;
    logic [WIDTH-1:0] hi;
    logic [CNT_W-1:0] cnt;
    logic [REG_W-1:0] dest_q;
    logic             long_q;
    logic [WIDTH:0]   sum;
    logic             last_iter;
    logic             grant;

    // One shift-add step: add the multiplicand into the high half when the
    // current multiplier bit is set; the carry shifts down into hi.
    always_comb begin
        sum = {1'b0, hi} + (mb[0] ? {1'b0, ma} : '0);
    end

    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    // WB owns the port whenever it asks for it.
    assign grant     = ~wb_stage_en;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, write-port arbitration and status outputs.
    always_comb begin
        state_nxt   = state;
        rf_wb_en    = wb_stage_en;
        rf_wb_dest  = wb_stage_dest;
        rf_wb_value = wb_stage_value;
        freeze      = (state != IDLE);
        done        = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_nxt = WR_LO;
                end
            end
            WR_LO: begin
                if (grant) begin
                    rf_wb_en    = 1'b1;
                    rf_wb_dest  = dest_q;
                    rf_wb_value = DATA_W'(mb);
                    if (long_q) begin
                        state_nxt = WR_HI;
                    end else begin
                        state_nxt = IDLE;
                        done      = 1'b1;
                    end
                end
            end
            WR_HI: begin
                if (grant) begin
                    rf_wb_en    = 1'b1;
                    // Rd=15 wraps to R0 through the 4-bit truncation.
                    rf_wb_dest  = REG_W'(dest_q + REG_W'(1));
                    rf_wb_value = DATA_W'(hi);
                    state_nxt   = IDLE;
                    done        = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand latch and multiply datapath; operands only captured on accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ma     <= '0;
            mb     <= '0;
            hi     <= '0;
            cnt    <= '0;
            dest_q <= '0;
            long_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ma     <= op_a;
                        mb     <= op_b;
                        hi     <= '0;
                        cnt    <= '0;
                        dest_q <= dest;
                        long_q <= is_long;
                    end
                end
                CALC: begin
                    // {hi, mb} <= {sum, mb >> 1}: mb fills with product low bits.
                    hi  <= sum[WIDTH:1];
                    mb  <= {sum[0], mb[WIDTH-1:1]};
                    cnt <= cnt + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
module tb_mul_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_long;
    logic [3:0]  dest;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        wb_stage_en;
    logic [3:0]  wb_stage_dest;
    logic [31:0] wb_stage_value;
    logic        rf_wb_en;
    logic [3:0]  rf_wb_dest;
    logic [31:0] rf_wb_value;
    logic        freeze;
    logic        done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mul_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .is_long        (is_long),
        .dest           (dest),
        .op_a           (op_a),
        .op_b           (op_b),
        .wb_stage_en    (wb_stage_en),
        .wb_stage_dest  (wb_stage_dest),
        .wb_stage_value (wb_stage_value),
        .rf_wb_en       (rf_wb_en),
        .rf_wb_dest     (rf_wb_dest),
        .rf_wb_value    (rf_wb_value),
        .freeze         (freeze),
        .done           (done)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        lng;
        logic [3:0]  d;
        int          cs;   // first cycle of WB conflict (cycle 1 = first CALC cycle)
        int          cl;   // conflict length in cycles
        int          ign;  // cycle of an ignored start pulse, 0 = none
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic bit in_conf(input int n, input int cs, input int cl);
        return (n >= cs) && (n < cs + cl);
    endfunction

    // Issues one multiply and checks the port/status outputs every cycle
    // against a timeline derived from the latency and WB-priority rules.
    task automatic run_op(input vec_t v, input logic [3:0] wd, input logic [31:0] wv);
        int wlo, whi, last;
        logic        e_en;
        logic [3:0]  e_dest;
        logic [31:0] e_val;
        wlo = 33;
        while (in_conf(wlo, v.cs, v.cl)) wlo++;
        whi  = -1;
        last = wlo;
        if (v.lng) begin
            whi = wlo + 1;
            while (in_conf(whi, v.cs, v.cl)) whi++;
            last = whi;
        end
        @(posedge clk); #1;
        start = 1'b1; op_a = v.a; op_b = v.b; is_long = v.lng; dest = v.d;
        wb_stage_en = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; op_a = $urandom; op_b = $urandom; is_long = ~v.lng; dest = 4'($urandom);
        for (int n = 1; n <= last + 3; n++) begin
            if (n > 1) begin
                @(posedge clk); #1;
            end
            start = (v.ign != 0) && (n == v.ign);
            if (start) op_a = 32'd9;
            wb_stage_en    = in_conf(n, v.cs, v.cl);
            wb_stage_dest  = wd;
            wb_stage_value = wv;
            @(negedge clk);
            if (wb_stage_en) begin
                e_en = 1'b1; e_dest = wd; e_val = wv;
            end else if (n == wlo) begin
                e_en = 1'b1; e_dest = v.d; e_val = v.exp_lo;
            end else if (n == whi) begin
                e_en = 1'b1; e_dest = 4'(v.d + 4'd1); e_val = v.exp_hi;
            end else begin
                e_en = 1'b0; e_dest = '0; e_val = '0;
            end
            check($sformatf("en c%0d", n), 32'(rf_wb_en), 32'(e_en));
            check($sformatf("freeze c%0d", n), 32'(freeze), 32'(n <= last));
            check($sformatf("done c%0d", n), 32'(done), 32'(n == last));
            if (e_en) begin
                check($sformatf("dest c%0d", n), 32'(rf_wb_dest), 32'(e_dest));
                check($sformatf("value c%0d", n), rf_wb_value, e_val);
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        wb_stage_en = 1'b0;
    endtask

    vec_t vecs[6];
    vec_t rv;

    initial begin
        logic [63:0] prod;

        rst = 1'b0; start = 1'b0; is_long = 1'b0; dest = '0; op_a = '0; op_b = '0;
        wb_stage_en = 1'b1; wb_stage_dest = 4'd5; wb_stage_value = 32'h0000_1234;

        // Reset state: WB passes straight through, sequencer quiet.
        #12;
        check("rst en passthru", 32'(rf_wb_en), 32'd1);
        check("rst dest passthru", 32'(rf_wb_dest), 32'd5);
        check("rst value passthru", rf_wb_value, 32'h0000_1234);
        check("rst freeze", 32'(freeze), 32'd0);
        check("rst done", 32'(done), 32'd0);
        wb_stage_en = 1'b0;
        #1;
        check("rst en idle", 32'(rf_wb_en), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        vecs[0] = '{32'd3, 32'd5, 1'b0, 4'd4, 0, 0, 0, 32'd15, 32'd0};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'd2, 0, 0, 0, 32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2] = '{32'd7, 32'd6, 1'b0, 4'd4, 33, 3, 0, 32'd42, 32'd0};
        vecs[3] = '{32'h8000_0000, 32'd4, 1'b1, 4'd15, 0, 0, 0, 32'h0000_0000, 32'h0000_0002};
        vecs[4] = '{32'd3, 32'd5, 1'b0, 4'd4, 0, 0, 5, 32'd15, 32'd0};
        vecs[5] = '{32'hFFFF_FFFF, 32'd2, 1'b1, 4'd9, 34, 2, 0, 32'hFFFF_FFFE, 32'h0000_0001};

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i], 4'd7, 32'h0000_00AA);
        end

        // WB traffic during CALC passes through without disturbing the multiply.
        run_op('{32'd0, 32'd123, 1'b1, 4'd0, 10, 2, 0, 32'd0, 32'd0}, 4'd3, 32'hDEAD_BEEF);

        // Reset mid-CALC: immediate abort, no write, no done.
        @(posedge clk); #1;
        start = 1'b1; op_a = 32'd3; op_b = 32'd5; is_long = 1'b1; dest = 4'd4;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 2; n <= 10; n++) begin
            @(posedge clk); #1;
        end
        check("pre-abort freeze", 32'(freeze), 32'd1);
        rst = 1'b0;
        #1;
        check("abort freeze", 32'(freeze), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort en", 32'(rf_wb_en), 32'd0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check($sformatf("abort hold en %0d", n), 32'(rf_wb_en), 32'd0);
            check($sformatf("abort hold freeze %0d", n), 32'(freeze), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rf_wb_en || freeze || done) begin
                check($sformatf("post-abort quiet %0d", n), {29'd0, rf_wb_en, freeze, done}, 32'd0);
            end
        end
        total++;
        run_op(vecs[0], 4'd7, 32'h0000_00AA);

        // Randomized operations against plain 64-bit multiplication.
        for (int i = 0; i < 10; i++) begin
            rv.a   = $urandom;
            rv.b   = $urandom;
            if (i == 0) rv.b = 32'd0;
            if (i == 1) rv.a = 32'hFFFF_FFFF;
            rv.lng = 1'($urandom);
            rv.d   = 4'($urandom);
            rv.cs  = int'($urandom_range(36, 30));
            rv.cl  = int'($urandom_range(3, 0));
            rv.ign = (i % 3 == 0) ? int'($urandom_range(30, 2)) : 0;
            prod   = 64'(rv.a) * 64'(rv.b);
            rv.exp_lo = prod[31:0];
            rv.exp_hi = prod[63:32];
            run_op(rv, 4'($urandom), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
